// File: rtl/timer_keypad_decoder.sv
// -----------------------------------------------------------------------------
// timer_keypad_decoder
//
// Consumer side of the keypad encoder link. Turns the encoder's digit bus and
// strobe into a 4-digit BCD mm:ss cook time and runs the countdown.
//   - IDLE / PAUSE : each strobe rising edge shifts D in from the right.
//   - RUN          : each strobe rising edge (the 1 Hz tick) decrements the time.
//   - DONE         : done held high for DONE_CYCLES clocks, then back to IDLE.
//
// Ports
//   clk        system clock, all state changes on posedge
//   clear_n    asynchronous active-low reset
//   D[3:0]     digit from the encoder (valid while pgt_1Hz is high in entry)
//   pgt_1Hz    encoder strobe: key pulse (entry) or 1 Hz tick (running)
//   start      level request to begin / resume cooking
//   stop       level request to pause, or clear when not running
//   min_tens, min_ones, sec_tens, sec_ones [3:0]  registered BCD time digits
//   running    high in RUN; drives the encoder mux select
//   done       high for DONE_CYCLES clocks when the countdown expires
//   zero       combinational: all four digits are 0
// -----------------------------------------------------------------------------
module timer_keypad_decoder #(
    parameter int DONE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [3:0] D,
    input  logic       pgt_1Hz,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter is loaded with DONE_CYCLES-1 so that done stays high for
    // exactly DONE_CYCLES clocks including the cycle it is first set.
    localparam logic [3:0] DONE_LOAD = 4'(DONE_CYCLES - 1);

    state_t     state_reg;
    logic       pgt_d_reg;
    logic [3:0] done_cnt_reg;
    logic       done_reg;
    logic [3:0] min_tens_reg;
    logic [3:0] min_ones_reg;
    logic [3:0] sec_tens_reg;
    logic [3:0] sec_ones_reg;

    logic       strobe;
    logic       digit_valid;
    logic [3:0] dec_min_tens;
    logic [3:0] dec_min_ones;
    logic [3:0] dec_sec_tens;
    logic [3:0] dec_sec_ones;
    logic       dec_zero;

    assign strobe      = pgt_1Hz & ~pgt_d_reg;
    assign digit_valid = (D <= 4'd9);

    assign zero = (min_tens_reg == 4'd0) && (min_ones_reg == 4'd0) &&
                  (sec_tens_reg == 4'd0) && (sec_ones_reg == 4'd0);

    // One-second decrement with a borrow chain. sec_tens may legally hold
    // 6..9 after keypad entry; it simply counts down from there, and only a
    // borrow out of a zero sec_tens wraps it to 5.
    always_comb begin
        dec_min_tens = min_tens_reg;
        dec_min_ones = min_ones_reg;
        dec_sec_tens = sec_tens_reg;
        dec_sec_ones = sec_ones_reg - 4'd1;
        if (sec_ones_reg == 4'd0) begin
            dec_sec_ones = 4'd9;
            if (sec_tens_reg == 4'd0) begin
                dec_sec_tens = 4'd5;
                if (min_ones_reg == 4'd0) begin
                    dec_min_ones = 4'd9;
                    dec_min_tens = min_tens_reg - 4'd1;
                end else begin
                    dec_min_ones = min_ones_reg - 4'd1;
                end
            end else begin
                dec_sec_tens = sec_tens_reg - 4'd1;
            end
        end
    end

    assign dec_zero = (dec_min_tens == 4'd0) && (dec_min_ones == 4'd0) &&
                      (dec_sec_tens == 4'd0) && (dec_sec_ones == 4'd0);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg    <= IDLE;
            pgt_d_reg    <= 1'b0;
            done_cnt_reg <= 4'd0;
            done_reg     <= 1'b0;
            min_tens_reg <= 4'd0;
            min_ones_reg <= 4'd0;
            sec_tens_reg <= 4'd0;
            sec_ones_reg <= 4'd0;
        end else begin
            pgt_d_reg <= pgt_1Hz;
            case (state_reg)
                // Entry states: stop clears, start (if time set) runs, and a
                // strobe arriving in the same cycle as start is dropped.
                IDLE, PAUSE: begin
                    if (stop) begin
                        state_reg    <= IDLE;
                        min_tens_reg <= 4'd0;
                        min_ones_reg <= 4'd0;
                        sec_tens_reg <= 4'd0;
                        sec_ones_reg <= 4'd0;
                    end else if (start) begin
                        if (!zero) begin
                            state_reg <= RUN;
                        end
                    end else if (strobe && digit_valid) begin
                        min_tens_reg <= min_ones_reg;
                        min_ones_reg <= sec_tens_reg;
                        sec_tens_reg <= sec_ones_reg;
                        sec_ones_reg <= D;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= PAUSE;
                    end else if (strobe) begin
                        min_tens_reg <= dec_min_tens;
                        min_ones_reg <= dec_min_ones;
                        sec_tens_reg <= dec_sec_tens;
                        sec_ones_reg <= dec_sec_ones;
                        if (dec_zero) begin
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            done_cnt_reg <= DONE_LOAD;
                        end
                    end
                end
                DONE: begin
                    if (stop || (done_cnt_reg == 4'd0)) begin
                        state_reg    <= IDLE;
                        done_reg     <= 1'b0;
                        done_cnt_reg <= 4'd0;
                    end else begin
                        done_cnt_reg <= done_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign running  = (state_reg == RUN);
    assign done     = done_reg;
    assign min_tens = min_tens_reg;
    assign min_ones = min_ones_reg;
    assign sec_tens = sec_tens_reg;
    assign sec_ones = sec_ones_reg;

endmodule

// File: tb/tb_timer_keypad_decoder.sv
// -----------------------------------------------------------------------------
// tb_timer_keypad_decoder
//
// Directed scenarios plus randomized episodes for timer_keypad_decoder. A
// behavioural model tracks the cook time as a list of keyed digits and as
// minutes/seconds arithmetic, and the mode as a small enumeration; every
// clock all DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_timer_keypad_decoder;

    localparam int DONE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [3:0] D;
    logic       pgt_1Hz;
    logic       start;
    logic       stop;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, zero;

    timer_keypad_decoder #(.DONE_CYCLES(DONE_CYCLES)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .D        (D),
        .pgt_1Hz  (pgt_1Hz),
        .start    (start),
        .stop     (stop),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .done     (done),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int done_seen = 0;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode;
    int m_dig [4];     // [0]=min_tens [1]=min_ones [2]=sec_tens [3]=sec_ones
    int m_done_left;
    bit m_pgt_prev;

    function automatic bit m_is_zero();
        return (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) == 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        foreach (m_dig[i]) m_dig[i] = 0;
        m_done_left = 0;
        m_pgt_prev  = 0;
    endtask

    task automatic model_clear();
        foreach (m_dig[i]) m_dig[i] = 0;
    endtask

    // One second less, computed on minutes and seconds as plain numbers.
    task automatic model_decrement();
        int mins, secs;
        mins = 10 * m_dig[0] + m_dig[1];
        secs = 10 * m_dig[2] + m_dig[3];
        if (secs > 0) secs = secs - 1;
        else begin
            mins = mins - 1;
            secs = 59;
        end
        m_dig[0] = mins / 10; m_dig[1] = mins % 10;
        m_dig[2] = secs / 10; m_dig[3] = secs % 10;
    endtask

    // Model behaviour for one clock edge using the inputs present now.
    task automatic model_step();
        bit stb;
        stb = pgt_1Hz && !m_pgt_prev;
        m_pgt_prev = pgt_1Hz;
        if (!clear_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE, M_PAUSE: begin
                if (stop) begin
                    model_clear();
                    m_mode = M_IDLE;
                end else if (start) begin
                    if (!m_is_zero()) m_mode = M_RUN;
                end else if (stb && D <= 9) begin
                    for (int i = 0; i < 3; i++) m_dig[i] = m_dig[i+1];
                    m_dig[3] = int'(D);
                end
            end
            M_RUN: begin
                if (stop) m_mode = M_PAUSE;
                else if (stb) begin
                    model_decrement();
                    if (m_is_zero()) begin
                        m_mode = M_DONE;
                        m_done_left = DONE_CYCLES;
                    end
                end
            end
            default: begin
                if (stop) m_mode = M_IDLE;
                else begin
                    m_done_left = m_done_left - 1;
                    if (m_done_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string where);
        check({where, ":min_tens"}, int'(min_tens), m_dig[0]);
        check({where, ":min_ones"}, int'(min_ones), m_dig[1]);
        check({where, ":sec_tens"}, int'(sec_tens), m_dig[2]);
        check({where, ":sec_ones"}, int'(sec_ones), m_dig[3]);
        check({where, ":running"}, int'(running), int'(m_mode == M_RUN));
        check({where, ":done"},    int'(done),    int'(m_mode == M_DONE));
        check({where, ":zero"},    int'(zero),    int'(m_is_zero()));
    endtask

    task automatic check_time(input string tag, input int mt, input int mo,
                              input int st, input int so);
        check({tag, ":mt"}, int'(min_tens), mt);
        check({tag, ":mo"}, int'(min_ones), mo);
        check({tag, ":st"}, int'(sec_tens), st);
        check({tag, ":so"}, int'(sec_ones), so);
    endtask

    // One clock: advance the model, take the edge, compare 1 ns later.
    task automatic tick(input string where);
        model_step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
        check_all(where);
    endtask

    task automatic pulse(input logic [3:0] d, input int hi, input int lo, input string where);
        D = d;
        pgt_1Hz = 1'b1;
        repeat (hi) tick(where);
        pgt_1Hz = 1'b0;
        repeat (lo) tick(where);
    endtask

    task automatic press_stop(input string where);
        stop = 1'b1; tick(where); stop = 1'b0;
    endtask

    task automatic press_start(input string where);
        start = 1'b1; tick(where); start = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0; D = 4'd0; pgt_1Hz = 1'b0; start = 1'b0; stop = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        repeat (2) tick("reset_hold");
        clear_n = 1'b1;
        tick("reset_rel");

        // 1: key entry 1,2,3,0 -> 12:30
        pulse(4'd1, 3, 5, "entry");
        pulse(4'd2, 3, 5, "entry");
        pulse(4'd3, 3, 5, "entry");
        pulse(4'd0, 3, 5, "entry");
        check_time("t1_1230", 1, 2, 3, 0);
        check("t1_running", int'(running), 0);

        // 2: 01:00 counts down through done
        press_stop("t2_clr");
        pulse(4'd1, 1, 1, "t2_load");
        pulse(4'd0, 1, 1, "t2_load");
        pulse(4'd0, 1, 1, "t2_load");
        press_start("t2_start");
        check("t2_running", int'(running), 1);
        pulse(4'd0, 1, 1, "t2_dec");
        check_time("t2_0059", 0, 0, 5, 9);
        done_seen = 0;
        for (int i = 0; i < 59; i++) pulse(4'd0, 1, 2, "t2_dec");
        repeat (6) tick("t2_tail");
        check("t2_done_len", done_seen, DONE_CYCLES);
        check("t2_idle", int'(running), 0);

        // 3: pause, shift while paused, resume, stop twice
        pulse(4'd0, 1, 1, "t3_load");
        pulse(4'd5, 1, 1, "t3_load");
        press_start("t3_start");
        pulse(4'd0, 1, 1, "t3_dec");
        pulse(4'd0, 1, 1, "t3_dec");
        press_stop("t3_pause");
        check_time("t3_0003", 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) pulse(4'd7, 1, 1, "t3_shift");
        check_time("t3_3777", 3, 7, 7, 7);
        press_start("t3_resume");
        check("t3_run", int'(running), 1);
        press_stop("t3_stop1");
        press_stop("t3_stop2");
        check_time("t3_cleared", 0, 0, 0, 0);

        // 4: start+stop together clears; start with 00:00 does nothing
        pulse(4'd1, 1, 1, "t4_load");
        pulse(4'd2, 1, 1, "t4_load");
        start = 1'b1; stop = 1'b1; tick("t4_both"); start = 1'b0; stop = 1'b0;
        check("t4_zero", int'(zero), 1);
        press_start("t4_zero_start");
        check("t4_norun", int'(running), 0);

        // 5: invalid digit, held strobe, strobe coincident with start
        pulse(4'd1, 1, 1, "t5_load");
        pulse(4'd2, 1, 1, "t5_load");
        pulse(4'hA, 2, 2, "t5_invalid");
        pulse(4'd3, 20, 2, "t5_held");
        check_time("t5_0123", 0, 1, 2, 3);
        D = 4'd0; pgt_1Hz = 1'b1; start = 1'b1; tick("t5_coinc");
        start = 1'b0; tick("t5_coinc"); pgt_1Hz = 1'b0; tick("t5_coinc");
        check_time("t5_nodec", 0, 1, 2, 3);
        pulse(4'd0, 1, 1, "t5_dec");
        check_time("t5_0122", 0, 1, 2, 2);

        // 6: asynchronous reset mid-run
        press_stop("t6_pause"); press_stop("t6_clr");
        pulse(4'd5, 1, 1, "t6_load");
        pulse(4'd3, 1, 1, "t6_load");
        pulse(4'd2, 1, 1, "t6_load");
        press_start("t6_start");
        pulse(4'd0, 1, 1, "t6_dec");
        check_time("t6_0531", 0, 5, 3, 1);
        #2 clear_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        tick("t6_hold");
        clear_n = 1'b1;
        tick("t6_rel");

        // Randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            press_stop("rnd_clr");
            for (int k = 0; k < 4; k++)
                pulse(4'($urandom_range(0, 11)), 1, $urandom_range(1, 2), "rnd_load");
            press_start("rnd_start");
            for (int c = 0; c < 200; c++) begin
                pgt_1Hz = ($urandom_range(0, 2) == 0);
                D       = 4'($urandom_range(0, 15));
                start   = ($urandom_range(0, 25) == 0);
                stop    = ($urandom_range(0, 40) == 0);
                tick("rnd");
            end
            start = 1'b0; stop = 1'b0; pgt_1Hz = 1'b0;
            tick("rnd_end");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
